// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward-select
// encodings and the destination-tracker entry.
package pipe_hazard_ctrl_pkg;

    // Tracker entries store destinations zero-extended to this width (REG_AW <= 8).
    localparam int TRK_AW = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } haz_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [TRK_AW-1:0] dest;
        logic              wr_en;
        logic              is_load;
    } trk_entry_t;

    function automatic logic entry_hit(trk_entry_t e, logic [TRK_AW-1:0] src, logic used);
        return e.valid & e.wr_en & used & (e.dest == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// pipe_fwd_match: compares one RR source against the ex/mem/wb tracker and
// returns the youngest forwarding source plus an EX-stage load hit.
module pipe_fwd_match
    import pipe_hazard_ctrl_pkg::*;
(
    input  trk_entry_t        i_ex,
    input  trk_entry_t        i_mem,
    input  trk_entry_t        i_wb,
    input  logic [TRK_AW-1:0] i_src,
    input  logic              i_src_used,
    output logic [1:0]        o_fwd_sel,
    output logic              o_load_hit
);

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;
    logic w_unused;

    assign w_hit_ex  = entry_hit(i_ex,  i_src, i_src_used);
    assign w_hit_mem = entry_hit(i_mem, i_src, i_src_used);
    assign w_hit_wb  = entry_hit(i_wb,  i_src, i_src_used);
    assign w_unused  = i_mem.is_load ^ i_wb.is_load;

    // Youngest producer wins.
    always_comb begin
        o_fwd_sel  = FWD_RF;
        o_load_hit = w_hit_ex & i_ex.is_load;
        if (w_hit_ex) begin
            o_fwd_sel = FWD_EX;
        end else if (w_hit_mem) begin
            o_fwd_sel = FWD_MEM;
        end else if (w_hit_wb) begin
            o_fwd_sel = FWD_WB;
        end else begin
            o_fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, branch flush and operand forwarding control for a 5-stage pipe.
// Optional performance counters are enabled with `define HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW    = 3,
    parameter int FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rr_valid,
    input  logic [REG_AW-1:0] rr_src1,
    input  logic [REG_AW-1:0] rr_src2,
    input  logic              rr_src1_used,
    input  logic              rr_src2_used,
    input  logic [REG_AW-1:0] rr_dest,
    input  logic              rr_wr_en,
    input  logic              rr_is_load,
    input  logic              br_taken,
    output logic              freeze,
    output logic              flush,
    output logic [1:0]        fwd1_sel,
    output logic [1:0]        fwd2_sel
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    trk_entry_t r_ex;
    trk_entry_t r_mem;
    trk_entry_t r_wb;
    trk_entry_t w_ex_nxt;
    haz_state_e r_state;
    haz_state_e w_state_nxt;
    logic [2:0] r_flush_cnt;
    logic [2:0] w_flush_cnt_nxt;
    logic [1:0] w_sel1;
    logic [1:0] w_sel2;
    logic       w_ld_hit1;
    logic       w_ld_hit2;
    logic       w_hazard;

    pipe_fwd_match u_match1 (
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .i_src      (TRK_AW'(rr_src1)),
        .i_src_used (rr_src1_used),
        .o_fwd_sel  (w_sel1),
        .o_load_hit (w_ld_hit1)
    );

    pipe_fwd_match u_match2 (
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .i_src      (TRK_AW'(rr_src2)),
        .i_src_used (rr_src2_used),
        .o_fwd_sel  (w_sel2),
        .o_load_hit (w_ld_hit2)
    );

    // A taken branch masks the hazard so freeze and flush are never both high.
    assign w_hazard = (r_state == ST_RUN) & (w_ld_hit1 | w_ld_hit2);
    assign freeze   = w_hazard & ~br_taken;
    assign flush    = br_taken | (r_state == ST_FLUSH);
    assign fwd1_sel = flush ? FWD_RF : w_sel1;
    assign fwd2_sel = flush ? FWD_RF : w_sel2;

    // Next-state, flush counter and incoming EX entry.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_ex_nxt        = '0;
        if (rr_valid & ~freeze & ~flush) begin
            w_ex_nxt.valid   = 1'b1;
            w_ex_nxt.dest    = TRK_AW'(rr_dest);
            w_ex_nxt.wr_en   = rr_wr_en;
            w_ex_nxt.is_load = rr_is_load;
        end else begin
            w_ex_nxt = '0;
        end
        if (br_taken) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = 3'(FLUSH_CYC - 1);
        end else begin
            case (r_state)
                ST_RUN:   w_state_nxt = w_hazard ? ST_STALL : ST_RUN;
                ST_STALL: w_state_nxt = ST_RUN;
                ST_FLUSH: begin
                    if (r_flush_cnt == 3'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                    end
                end
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    // Tracker shift and FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_ex        <= w_ex_nxt;
            r_mem       <= r_ex;
            r_wb        <= r_mem;
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_ev_cnt;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt    <= 16'd0;
            r_flush_ev_cnt <= 16'd0;
        end else begin
            if (freeze && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (br_taken && (r_flush_ev_cnt != 16'hFFFF)) begin
                r_flush_ev_cnt <= r_flush_ev_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_ev_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic against a behavioural pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int AW   = 3;
    localparam int FCYC = 2;

    logic clk = 1'b0;
    logic rst, rr_valid, rr_src1_used, rr_src2_used, rr_wr_en, rr_is_load, br_taken;
    logic [AW-1:0] rr_src1, rr_src2, rr_dest;
    logic freeze, flush;
    logic [1:0] fwd1_sel, fwd2_sel;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: pipeline slots 0=EX,1=MEM,2=WB; flush cycles still to come; stall flag.
    bit m_v[3];
    int m_d[3];
    bit m_we[3];
    bit m_ld[3];
    int m_flush_left = 0;
    bit m_in_stall   = 1'b0;
    int m_stall_cnt  = 0;
    int m_flush_cnt  = 0;
    bit m_flush, m_freeze, m_hazard;
    int m_f1, m_f2;

    pipe_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYC(FCYC)) dut (
        .clk(clk), .rst(rst), .rr_valid(rr_valid),
        .rr_src1(rr_src1), .rr_src2(rr_src2),
        .rr_src1_used(rr_src1_used), .rr_src2_used(rr_src2_used),
        .rr_dest(rr_dest), .rr_wr_en(rr_wr_en), .rr_is_load(rr_is_load),
        .br_taken(br_taken), .freeze(freeze), .flush(flush),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int model_fwd(int src, bit used);
        for (int i = 0; i < 3; i++) begin
            if (used && m_v[i] && m_we[i] && (m_d[i] == src)) return i + 1;
        end
        return 0;
    endfunction

    task automatic set_in(input bit r, input bit b, input bit v,
                          input int s1, input bit u1, input int s2, input bit u2,
                          input int d, input bit we, input bit ld);
        @(negedge clk);
        rst = r; br_taken = b; rr_valid = v;
        rr_src1 = AW'(s1); rr_src1_used = u1;
        rr_src2 = AW'(s2); rr_src2_used = u2;
        rr_dest = AW'(d); rr_wr_en = we; rr_is_load = ld;
        #1;
        m_flush  = b || (m_flush_left > 0);
        m_hazard = (m_flush_left == 0) && !m_in_stall && m_v[0] && m_we[0] && m_ld[0] &&
                   ((u1 && m_d[0] == s1) || (u2 && m_d[0] == s2));
        m_freeze = m_hazard && !b;
        m_f1 = m_flush ? 0 : model_fwd(s1, u1);
        m_f2 = m_flush ? 0 : model_fwd(s2, u2);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
            m_flush_left = 0; m_in_stall = 1'b0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; m_we[i] = m_we[i-1]; m_ld[i] = m_ld[i-1];
            end
            m_v[0]  = rr_valid && !m_freeze && !m_flush;
            m_d[0]  = int'(rr_dest); m_we[0] = rr_wr_en; m_ld[0] = rr_is_load;
            if (m_freeze && m_stall_cnt < 65535) m_stall_cnt++;
            if (br_taken && m_flush_cnt < 65535) m_flush_cnt++;
            if (br_taken) begin
                m_flush_left = FCYC; m_in_stall = 1'b0;
            end else if (m_flush_left > 0) begin
                m_flush_left--; m_in_stall = 1'b0;
            end else begin
                m_in_stall = m_hazard;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            advance();
        end
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); advance();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); advance();
        set_in(0, 0, 1, 1, 1, 2, 1, 3, 1, 0);
        n_checks++;
        if ({freeze, flush, fwd1_sel, fwd2_sel} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_outputs got fr=%0b fl=%0b f1=%0d f2=%0d exp all 0", freeze, flush, fwd1_sel, fwd2_sel);
        end
`ifdef HAZ_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        end
`endif
        advance();
        idle(3);
    endtask

    task automatic test_load_use();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); advance();
        set_in(0, 0, 1, 0, 0, 0, 0, 3, 1, 1); advance();
        set_in(0, 0, 1, 3, 1, 4, 1, 5, 1, 0);
        n_checks++;
        if (freeze !== 1'b1) begin
            n_errors++; $display("FAIL load_use_freeze got %0b exp 1", freeze);
        end
        advance();
        set_in(0, 0, 1, 3, 1, 4, 1, 5, 1, 0);
        n_checks++;
        if (freeze !== 1'b0 || fwd1_sel !== 2'd2) begin
            n_errors++; $display("FAIL load_use_post got fr=%0b f1=%0d exp fr=0 f1=2", freeze, fwd1_sel);
        end
`ifdef HAZ_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd1) begin
            n_errors++; $display("FAIL load_use_stall_cnt got %0d exp 1", stall_cnt);
        end
`endif
        advance();
        idle(3);
    endtask

    task automatic test_youngest();
        set_in(0, 0, 1, 0, 0, 0, 0, 2, 1, 0); advance();
        set_in(0, 0, 1, 0, 0, 0, 0, 2, 1, 0); advance();
        set_in(0, 0, 1, 2, 1, 2, 1, 6, 0, 0);
        n_checks++;
        if (fwd1_sel !== 2'd1 || fwd2_sel !== 2'd1 || freeze !== 1'b0) begin
            n_errors++; $display("FAIL youngest got f1=%0d f2=%0d fr=%0b exp 1 1 0", fwd1_sel, fwd2_sel, freeze);
        end
        advance();
        idle(3);
    endtask

    task automatic test_both_src();
        set_in(0, 0, 1, 0, 0, 0, 0, 5, 1, 1); advance();
        set_in(0, 0, 1, 5, 1, 5, 1, 1, 1, 0);
        n_checks++;
        if (freeze !== 1'b1) begin
            n_errors++; $display("FAIL both_src_freeze got %0b exp 1", freeze);
        end
        advance();
        set_in(0, 0, 1, 5, 1, 5, 1, 1, 1, 0);
        n_checks++;
        if (freeze !== 1'b0 || fwd1_sel !== 2'd2 || fwd2_sel !== 2'd2) begin
            n_errors++; $display("FAIL both_src_single got fr=%0b f1=%0d f2=%0d exp 0 2 2", freeze, fwd1_sel, fwd2_sel);
        end
        advance();
        idle(3);
    endtask

    task automatic test_branch_flush();
        set_in(0, 1, 1, 0, 0, 0, 0, 6, 1, 0);
        n_checks++;
        if (flush !== 1'b1 || freeze !== 1'b0) begin
            n_errors++; $display("FAIL br_cycle got fl=%0b fr=%0b exp 1 0", flush, freeze);
        end
        advance();
        for (int c = 0; c < FCYC; c++) begin
            set_in(0, 0, 1, 6, 1, 0, 0, 6, 1, 0);
            n_checks++;
            if (flush !== 1'b1 || fwd1_sel !== 2'd0) begin
                n_errors++; $display("FAIL br_hold[%0d] got fl=%0b f1=%0d exp 1 0", c, flush, fwd1_sel);
            end
            advance();
        end
        set_in(0, 0, 1, 6, 1, 0, 0, 1, 1, 0);
        n_checks++;
        if (flush !== 1'b0 || fwd1_sel !== 2'd0) begin
            n_errors++; $display("FAIL br_end got fl=%0b f1=%0d exp 0 0", flush, fwd1_sel);
        end
        advance();
        idle(3);
    endtask

    task automatic test_branch_vs_hazard();
        set_in(0, 0, 1, 0, 0, 0, 0, 3, 1, 1); advance();
        set_in(0, 1, 1, 3, 1, 0, 0, 2, 1, 0);
        n_checks++;
        if (freeze !== 1'b0 || flush !== 1'b1) begin
            n_errors++; $display("FAIL br_vs_haz got fr=%0b fl=%0b exp 0 1", freeze, flush);
        end
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (flush !== 1'b1 || freeze !== 1'b0) begin
            n_errors++; $display("FAIL br_vs_haz_next got fl=%0b fr=%0b exp 1 0", flush, freeze);
        end
`ifdef HAZ_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'(m_stall_cnt) || flush_cnt !== 16'(m_flush_cnt)) begin
            n_errors++; $display("FAIL br_vs_haz_cnt got %0d/%0d exp %0d/%0d", stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
        end
`endif
        advance();
        idle(4);
    endtask

    task automatic test_reset_mid_flush();
        set_in(0, 0, 1, 0, 0, 0, 0, 4, 1, 0); advance();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); advance();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); advance();
        set_in(0, 0, 1, 4, 1, 4, 1, 1, 1, 0);
        n_checks++;
        if (flush !== 1'b0 || freeze !== 1'b0 || fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_mid_flush got fl=%0b fr=%0b f1=%0d f2=%0d exp all 0", flush, freeze, fwd1_sel, fwd2_sel);
        end
        advance();
        idle(3);
    endtask

    task automatic test_src_unused();
        set_in(0, 0, 1, 0, 0, 0, 0, 3, 1, 1); advance();
        set_in(0, 0, 1, 3, 0, 5, 1, 1, 1, 0);
        n_checks++;
        if (freeze !== 1'b0 || fwd1_sel !== 2'd0) begin
            n_errors++; $display("FAIL src_unused got fr=%0b f1=%0d exp 0 0", freeze, fwd1_sel);
        end
        advance();
        idle(3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                   int'($urandom_range(7)), bit'($urandom_range(1)),
                   int'($urandom_range(7)), bit'($urandom_range(1)),
                   int'($urandom_range(7)), ($urandom_range(3) != 0), bit'($urandom_range(1)));
            n_checks++;
            if (freeze !== m_freeze || flush !== m_flush) begin
                n_errors++; $display("FAIL rand_ctl[%0d] got fr=%0b fl=%0b exp %0b %0b", n, freeze, flush, m_freeze, m_flush);
            end
            n_checks++;
            if (fwd1_sel !== 2'(m_f1) || fwd2_sel !== 2'(m_f2)) begin
                n_errors++; $display("FAIL rand_fwd[%0d] got %0d %0d exp %0d %0d", n, fwd1_sel, fwd2_sel, m_f1, m_f2);
            end
`ifdef HAZ_PERF_CNT_EN
            n_checks++;
            if (stall_cnt !== 16'(m_stall_cnt) || flush_cnt !== 16'(m_flush_cnt)) begin
                n_errors++; $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", n, stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
            end
`endif
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
        test_reset();
        test_load_use();
        test_youngest();
        test_both_src();
        test_branch_flush();
        test_branch_vs_hazard();
        test_reset_mid_flush();
        test_src_unused();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
